exec_unit: RTL and testbench

Multicycle execute stage that runs while the sequencer is in SCALC. It captures the decoded opcode and operands during SLOAD2 and performs the ALU, multiply or divide operation. It then produces the sequencer's nxt_line, finish and err inputs, and holds the result for the SWRITE writeback.

---
 rtl/exec_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_exec_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Multicycle execute stage: single-cycle ALU ops, shift-add multiply and
// restoring divide, with sticky HALT/fault reporting to the sequencer.
module exec_unit #(
  parameter int         WIDTH      = 8,
  parameter logic [2:0] SEQ_SLOAD2 = 3'd3,
  parameter logic [2:0] SEQ_SCALC  = 3'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       seq_state,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             nxt_line,
  output logic             finish,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] K_MUL = 2'd0;
  localparam logic [1:0] K_DIV = 2'd1;
  localparam logic [1:0] K_MOD = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} fsm_e;

  fsm_e               state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         opc_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         kind_q, kind_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_nxt_s;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rem_nxt_s, quo_nxt_s, r_diff_s;
  logic [WIDTH:0]     r_sh_s;
  logic               ge_s;
  logic [WIDTH-1:0]   result_q, result_d, sc_res_s;
  logic               carry_q, carry_d, zero_q, zero_d, sc_carry_s;
  logic               finish_q, finish_d, err_q, err_d;
  logic [1:0]         errc_q, errc_d;
  logic [WIDTH:0]     shl_w_s, shr_w_s;
  logic               scalc_s, sticky_s;

  assign scalc_s  = (seq_state == SEQ_SCALC);
  assign sticky_s = finish_q | err_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scalc_s && !sticky_s) begin
          case (opc_q)
            OP_NOP, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_SHL, OP_SHR: state_d = DONE;
            OP_MUL:                        state_d = BUSY;
            OP_DIV, OP_MOD:                state_d = (b_q != '0) ? BUSY : IDLE;
            default:                       state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!scalc_s)                 state_d = IDLE;
        else if (cnt_q == CW'(1))     state_d = DONE;
        else                          state_d = BUSY;
      end
      DONE: begin
        if (!scalc_s) state_d = IDLE;
        else          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode: completion is a pure function of the state register
  always_comb begin
    nxt_line = (state_q == DONE);
  end

  // Single-cycle ALU results from the latched operands
  always_comb begin
    shl_w_s    = {1'b0, a_q} << b_q[SW-1:0];
    shr_w_s    = {a_q, 1'b0} >> b_q[SW-1:0];
    sc_res_s   = result_q;
    sc_carry_s = 1'b0;
    case (opc_q)
      OP_ADD:  {sc_carry_s, sc_res_s} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {sc_carry_s, sc_res_s} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  sc_res_s = a_q & b_q;
      OP_OR:   sc_res_s = a_q | b_q;
      OP_XOR:  sc_res_s = a_q ^ b_q;
      OP_SHL:  {sc_carry_s, sc_res_s} = shl_w_s;
      OP_SHR:  {sc_res_s, sc_carry_s} = shr_w_s;
      default: sc_carry_s = 1'b0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    prod_nxt_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    r_sh_s     = {rem_q, quo_q[WIDTH-1]};
    ge_s       = (r_sh_s >= {1'b0, dvsr_q});
    r_diff_s   = r_sh_s[WIDTH-1:0] - dvsr_q;
    rem_nxt_s  = ge_s ? r_diff_s : r_sh_s[WIDTH-1:0];
    quo_nxt_s  = {quo_q[WIDTH-2:0], ge_s};
  end

  // Datapath and status next-state
  always_comb begin
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    finish_d = finish_q;
    err_d    = err_q;
    errc_d   = errc_q;
    case (state_q)
      IDLE: begin
        if (scalc_s && !sticky_s) begin
          mcand_d  = {{WIDTH{1'b0}}, a_q};
          mplier_d = b_q;
          prod_d   = '0;
          rem_d    = '0;
          quo_d    = a_q;
          dvsr_d   = b_q;
          case (opc_q)
            OP_NOP: cnt_d = '0;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
              result_d = sc_res_s;
              carry_d  = sc_carry_s;
              zero_d   = (sc_res_s == '0);
            end
            OP_MUL: begin
              kind_d = K_MUL;
              cnt_d  = CW'(WIDTH);
            end
            OP_DIV, OP_MOD: begin
              if (b_q == '0) begin
                err_d  = 1'b1;
                errc_d = 2'd2;
              end else begin
                kind_d = (opc_q == OP_DIV) ? K_DIV : K_MOD;
                cnt_d  = CW'(WIDTH);
              end
            end
            OP_HALT: finish_d = 1'b1;
            default: begin
              err_d  = 1'b1;
              errc_d = 2'd1;
            end
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        if (scalc_s) begin
          cnt_d    = cnt_q - CW'(1);
          prod_d   = prod_nxt_s;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          rem_d    = rem_nxt_s;
          quo_d    = quo_nxt_s;
          if (cnt_q == CW'(1)) begin
            case (kind_q)
              K_MUL: begin
                result_d = prod_nxt_s[WIDTH-1:0];
                carry_d  = |prod_nxt_s[2*WIDTH-1:WIDTH];
                zero_d   = (prod_nxt_s[WIDTH-1:0] == '0);
              end
              K_DIV: begin
                result_d = quo_nxt_s;
                carry_d  = 1'b0;
                zero_d   = (quo_nxt_s == '0);
              end
              default: begin
                result_d = rem_nxt_s;
                carry_d  = 1'b0;
                zero_d   = (rem_nxt_s == '0);
              end
            endcase
          end else begin
            result_d = result_q;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers; operands are captured only during SLOAD2
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      kind_q   <= K_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      errc_q   <= 2'd0;
    end else begin
      if (seq_state == SEQ_SLOAD2) begin
        opc_q <= opcode;
        a_q   <= op_a;
        b_q   <= op_b;
      end
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      finish_q <= finish_d;
      err_q    <= err_d;
      errc_q   <= errc_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign finish   = finish_q;
  assign err      = err_q;
  assign err_code = errc_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: expectations queued at SLOAD2, checked when
// nxt_line rises, plus directed error/halt/abort/reset scenarios.
module tb_exec_unit;

  localparam int W = 8;
  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD2 = 3'd3;
  localparam logic [2:0] S_CALC  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   seq_state;
  logic [3:0]   opcode;
  logic [W-1:0] op_a, op_b, result;
  logic         carry, zero, nxt_line, finish, err;
  logic [1:0]   err_code;

  exp_t         sb[$];
  logic [W-1:0] exp_r;
  logic         exp_c, exp_z;
  int           n_cmp = 0;
  int           n_bad = 0;

  exec_unit #(.WIDTH(W), .SEQ_SLOAD2(S_LOAD2), .SEQ_SCALC(S_CALC)) dut (
    .clk(clk), .rst(rst), .seq_state(seq_state), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .result(result), .carry(carry), .zero(zero),
    .nxt_line(nxt_line), .finish(finish), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    seq_state = S_RST;
    tick();
    rst   = 1'b0;
    exp_r = '0;
    exp_c = 1'b0;
    exp_z = 1'b0;
  endtask

  // Reference model: native operators, updates the expected architectural state
  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   t, r;
    logic           c, upd;
    exp_t           e;
    int             lat;
    lat = 2; upd = 1'b1; c = 1'b0; r = exp_r; t = a;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      4'd2: begin r = a - b; c = (a < b); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin
        for (int i = 0; i < int'(b[2:0]); i++) begin c = t[W-1]; t = t << 1; end
        r = t;
      end
      4'd7: begin
        for (int i = 0; i < int'(b[2:0]); i++) begin c = t[0]; t = t >> 1; end
        r = t;
      end
      4'd8: begin p = a * b; r = p[W-1:0]; c = |p[2*W-1:W]; lat = W + 2; end
      4'd9: begin r = a / b; lat = W + 2; end
      4'd10: begin r = a % b; lat = W + 2; end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      exp_r = r;
      exp_c = c;
      exp_z = (r == '0);
    end
    e.r = exp_r; e.c = exp_c; e.z = exp_z; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   cyc;
    logic seen;
    seq_state = S_LOAD2; opcode = op; op_a = a; op_b = b;
    tick();
    push_exp(op, a, b);
    // scramble the operand inputs: they must be ignored outside SLOAD2
    seq_state = S_CALC; opcode = 4'hD; op_a = ~a; op_b = 8'h00;
    seen = 1'b0;
    cyc  = 1;
    while (!seen && cyc <= 3 * W) begin
      if (nxt_line) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk("nxt_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk("latency", cyc, e.lat);
      chk("result", 32'(result), 32'(e.r));
      chk("carry", 32'(carry), 32'(e.c));
      chk("zero", 32'(zero), 32'(e.z));
      chk("err_clear", 32'(err), 32'd0);
    end
    seq_state = S_WRITE;
    tick();
    chk("nxt_drop", 32'(nxt_line), 32'd0);
    seq_state = S_FETCH;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    opcode = 4'd0; op_a = '0; op_b = '0;
    do_reset();
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {carry, zero, nxt_line, finish, err, err_code}, 32'd0);

    // ADD / MUL / DIV / MOD and assorted single-cycle patterns
    run_op(4'd1, 8'hF0, 8'h20);
    run_op(4'd8, 8'd13, 8'd11);
    run_op(4'd8, 8'd20, 8'd20);
    run_op(4'd9, 8'd200, 8'd7);
    run_op(4'd10, 8'd200, 8'd7);
    run_op(4'd9, 8'd7, 8'd200);
    run_op(4'd0, 8'h55, 8'h66);
    run_op(4'd2, 8'd5, 8'd9);
    run_op(4'd6, 8'h81, 8'd1);
    run_op(4'd7, 8'h81, 8'd1);
    run_op(4'd7, 8'h81, 8'd8);
    run_op(4'd6, 8'h0F, 8'd7);
    run_op(4'd5, 8'hA5, 8'hA5);
    run_op(4'd3, 8'hF3, 8'h3C);
    run_op(4'd4, 8'h10, 8'h01);
    run_op(4'd8, 8'hFF, 8'hFF);
    run_op(4'd9, 8'hFF, 8'd1);

    // Abort mid-multiply: previous result must survive
    run_op(4'd1, 8'd3, 8'd4);
    seq_state = S_LOAD2; opcode = 4'd8; op_a = 8'd7; op_b = 8'd9;
    tick();
    seq_state = S_CALC;
    repeat (3) tick();
    seq_state = S_ERR;
    tick();
    chk("abort_nxt", 32'(nxt_line), 32'd0);
    chk("abort_result", 32'(result), 32'(exp_r));
    seq_state = S_FETCH;
    tick();
    chk("abort_nxt_idle", 32'(nxt_line), 32'd0);
    run_op(4'd1, 8'd10, 8'd20);

    // Divide by zero: sticky error, no completion, result kept
    seq_state = S_LOAD2; opcode = 4'd9; op_a = 8'd9; op_b = 8'd0;
    tick();
    seq_state = S_CALC;
    tick();
    chk("div0_err", 32'(err), 32'd1);
    chk("div0_code", 32'(err_code), 32'd2);
    chk("div0_result", 32'(result), 32'(exp_r));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("div0_nxt", 32'(nxt_line), 32'd0);
      chk("div0_sticky", 32'(err), 32'd1);
    end
    do_reset();
    chk("div0_rst", 32'(err), 32'd0);

    // HALT: sticky finish, later illegal opcode ignored
    seq_state = S_LOAD2; opcode = 4'd15;
    tick();
    seq_state = S_CALC;
    tick();
    chk("halt_finish", 32'(finish), 32'd1);
    chk("halt_nxt", 32'(nxt_line), 32'd0);
    seq_state = S_LOAD2; opcode = 4'd13;
    tick();
    seq_state = S_CALC;
    tick();
    chk("halt_ill_err", 32'(err), 32'd0);
    chk("halt_ill_fin", 32'(finish), 32'd1);
    do_reset();
    chk("halt_rst", 32'(finish), 32'd0);

    // Illegal opcode alone
    seq_state = S_LOAD2; opcode = 4'd12;
    tick();
    seq_state = S_CALC;
    tick();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_code", 32'(err_code), 32'd1);
    chk("ill_nxt", 32'(nxt_line), 32'd0);
    do_reset();

    // Reset during BUSY cycle 4 of a MUL
    run_op(4'd1, 8'd5, 8'd6);
    seq_state = S_LOAD2; opcode = 4'd8; op_a = 8'd3; op_b = 8'd4;
    tick();
    seq_state = S_CALC;
    repeat (4) tick();
    do_reset();
    chk("busy_rst_result", 32'(result), 32'd0);
    chk("busy_rst_flags", {carry, zero, nxt_line, finish, err, err_code}, 32'd0);
    seq_state = S_FETCH;
    repeat (W + 2) tick();
    chk("busy_rst_idle", 32'(nxt_line), 32'd0);
    run_op(4'd1, 8'd1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
